// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM state encoding,
// exception source indices and the default vector base address.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2
  } exc_state_t;

  localparam int EXC_OPCODE   = 0;
  localparam int EXC_OVF      = 1;
  localparam int EXC_DIV0     = 2;
  localparam int DEF_VEC_BASE = 253;

  // Width of an exception index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational highest-index-wins priority encoder over the exception
// request lines; valid is high when any line is set.
module exc_prio_enc #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Later (higher) indices overwrite earlier ones, so the top set bit wins.
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Exception sequencer: accepts the highest-index request, latches EPC/cause,
// fetches the handler byte from VEC_BASE + cause and strobes a PC load.
// Optional macro EXC_PENDING_EN adds a sticky pending register so requests
// raised while busy are serviced afterwards instead of being dropped.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates exc_req (plus pending)
// READ  | vector slot read in flight; counter runs down to the data edge
// LOAD  | pc_wr strobe cycle; its exit edge arbitrates exactly like IDLE
module exception_unit
  import exc_pkg::*;
#(
  parameter int NUM_EXC  = 3,
  parameter int VEC_BASE = DEF_VEC_BASE,
  parameter int MEM_LAT  = 2,
  parameter int EPC_ADJ  = 4,
  localparam int CW      = idx_w(NUM_EXC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        mem_data,
  output logic [31:0]        mem_addr,
  output logic               mem_rd,
  output logic [31:0]        pc_out,
  output logic               pc_wr,
  output logic [31:0]        epc,
  output logic [CW-1:0]      cause,
  output logic               exc_busy
);

  exc_state_t         state;
  logic [2:0]         cnt;
  logic [NUM_EXC-1:0] arb_req;
  logic               win_valid;
  logic [CW-1:0]      win_idx;
  logic               accept;
  logic               unused_mem_hi;

  assign unused_mem_hi = ^mem_data[31:8];

  exc_prio_enc #(
    .N (NUM_EXC),
    .W (CW)
  ) u_prio (
    .req   (arb_req),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign accept = win_valid && ((state == IDLE) || (state == LOAD));

`ifdef EXC_PENDING_EN
  logic [NUM_EXC-1:0] pend;
  logic [NUM_EXC-1:0] pend_acc;
  logic [NUM_EXC-1:0] win_mask;

  // Outside IDLE every live request is folded into the sticky set.
  assign pend_acc = (state == IDLE) ? pend : (pend | exc_req);
  assign arb_req  = exc_req | pend;
  assign win_mask = {{(NUM_EXC-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (accept) begin
      pend <= pend_acc & ~win_mask;
    end else begin
      pend <= pend_acc;
    end
  end
`else
  assign arb_req = exc_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      pc_out   <= '0;
      pc_wr    <= 1'b0;
      epc      <= '0;
      cause    <= '0;
      exc_busy <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          pc_wr <= 1'b0;
          if (accept) begin
            epc      <= pc_in - 32'(EPC_ADJ);
            cause    <= win_idx;
            mem_addr <= 32'(VEC_BASE) + 32'(win_idx);
            mem_rd   <= 1'b1;
            cnt      <= 3'(MEM_LAT - 1);
            exc_busy <= 1'b1;
            state    <= READ;
          end else begin
            exc_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        READ: begin
          if (cnt == 3'd0) begin
            pc_out <= {24'h0, mem_data[7:0]};
            mem_rd <= 1'b0;
            pc_wr  <= 1'b1;
            state  <= LOAD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed vectors, multi-cycle
// corner sequences and a randomized run against a cycle-age reference model.
module tb_exception_unit;

  localparam int ML  = 2;
  localparam int VB  = 253;
  localparam int ADJ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  exc_req = 3'b000;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] mem_data = 32'h0;

  logic [31:0] mem_addr, pc_out, epc;
  logic        mem_rd, pc_wr, exc_busy;
  logic [1:0]  cause;

  logic [31:0] d1_mem_addr, d1_pc_out, d1_epc;
  logic        d1_mem_rd, d1_pc_wr, d1_exc_busy;
  logic [1:0]  d1_cause;

  always #5 clk = ~clk;

  exception_unit #(.NUM_EXC(3), .VEC_BASE(VB), .MEM_LAT(ML), .EPC_ADJ(ADJ)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .pc_in(pc_in), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .pc_out(pc_out), .pc_wr(pc_wr),
    .epc(epc), .cause(cause), .exc_busy(exc_busy)
  );

  exception_unit #(.NUM_EXC(3), .VEC_BASE(VB), .MEM_LAT(1), .EPC_ADJ(ADJ)) dut1 (
    .clk(clk), .reset(reset), .exc_req(exc_req), .pc_in(pc_in), .mem_data(mem_data),
    .mem_addr(d1_mem_addr), .mem_rd(d1_mem_rd), .pc_out(d1_pc_out), .pc_wr(d1_pc_wr),
    .epc(d1_epc), .cause(d1_cause), .exc_busy(d1_exc_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset   = 1'b1;
    exc_req = 3'b000;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] e_cause;
    logic [31:0] e_addr;
    logic [31:0] e_epc;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[5];

  task automatic run_vec(input vec_t v, input int k);
    int rd_cnt, busy_cnt, wr_cnt, wr_at;
    string tag;
    tag = $sformatf("vec%0d", k);
    @(negedge clk);
    exc_req  = v.req;
    pc_in    = v.pc;
    mem_data = v.data;
    rd_cnt = 0; busy_cnt = 0; wr_cnt = 0; wr_at = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exc_req = 3'b000;
      if (i == 1) begin
        chk({tag, " cause"}, 32'(cause), v.e_cause);
        chk({tag, " mem_addr"}, mem_addr, v.e_addr);
        chk({tag, " epc"}, epc, v.e_epc);
      end
      if (mem_rd) rd_cnt++;
      if (exc_busy) busy_cnt++;
      if (pc_wr) begin
        wr_cnt++;
        if (wr_at < 0) wr_at = i;
      end
    end
    chk({tag, " pc_out"}, pc_out, v.e_pc);
    chk({tag, " mem_rd cycles"}, 32'(rd_cnt), 32'(ML));
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(ML + 1));
    chk({tag, " pc_wr cycles"}, 32'(wr_cnt), 32'd1);
    chk({tag, " pc_wr offset"}, 32'(wr_at), 32'(ML + 1));
  endtask

  // Reference model: age counts edges since acceptance (0 = idle).
  int          age;
  int          win;
  logic [2:0]  pend, cand;
  logic [31:0] m_addr, m_pc, m_epc;
  logic [1:0]  m_cause;

  task automatic model_step();
    if (reset) begin
      age = 0; pend = 3'b000;
      m_addr = 0; m_pc = 0; m_epc = 0; m_cause = 0;
    end else if (age == 0 || age == ML + 1) begin
      cand = exc_req;
`ifdef EXC_PENDING_EN
      cand = exc_req | pend;
      if (age != 0) pend = pend | exc_req;
`endif
      if (cand != 3'b000) begin
        win = 0;
        for (int b = 0; b < 3; b++) if (cand[b]) win = b;
        m_epc   = pc_in - ADJ;
        m_cause = 2'(win);
        m_addr  = VB + win;
        pend[win] = 1'b0;
        age = 1;
      end else begin
        age = 0;
      end
    end else begin
`ifdef EXC_PENDING_EN
      pend = pend | exc_req;
`endif
      if (age == ML) m_pc = {24'h0, mem_data[7:0]};
      age++;
    end
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, at;

    vt[0] = '{3'b001, 32'h0000_0040, 32'h0000_0080, 32'd0, 32'd253, 32'h0000_003C, 32'h80};
    vt[1] = '{3'b110, 32'h0000_1234, 32'h5A5A_5A11, 32'd2, 32'd255, 32'h0000_1230, 32'h11};
    vt[2] = '{3'b011, 32'h0000_0100, 32'h0000_0022, 32'd1, 32'd254, 32'h0000_00FC, 32'h22};
    vt[3] = '{3'b100, 32'h0000_0002, 32'hFFFF_FF00, 32'd2, 32'd255, 32'hFFFF_FFFE, 32'h00};
    vt[4] = '{3'b010, 32'h8000_0000, 32'h0000_00C3, 32'd1, 32'd254, 32'h7FFF_FFFC, 32'hC3};

    do_reset(2);
    chk("rst mem_rd", 32'(mem_rd), 0);
    chk("rst pc_wr", 32'(pc_wr), 0);
    chk("rst busy", 32'(exc_busy), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst epc", epc, 0);
    chk("rst pc_out", pc_out, 0);
    chk("rst cause", 32'(cause), 0);

    for (int k = 0; k < 5; k++) run_vec(vt[k], k);

    // Reset mid-READ with all requests asserted.
    do_reset(1);
    @(negedge clk);
    exc_req = 3'b111; pc_in = 32'h0000_0500; mem_data = 32'h0000_0077;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst mem_rd", 32'(mem_rd), 0);
    chk("midrst pc_wr", 32'(pc_wr), 0);
    chk("midrst busy", 32'(exc_busy), 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst epc", epc, 0);
    chk("midrst cause", 32'(cause), 0);
    chk("midrst pc_out", pc_out, 0);
    reset = 1'b0; exc_req = 3'b000;
    cnt_a = 0;
    repeat (6) begin
      @(negedge clk);
      if (pc_wr || exc_busy || mem_rd) cnt_a++;
    end
    chk("postrst quiet", 32'(cnt_a), 0);

    // MEM_LAT=1 instance.
    do_reset(1);
    @(negedge clk);
    exc_req = 3'b010; pc_in = 32'h0000_0044; mem_data = 32'h0000_0039;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; at = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exc_req = 3'b000;
      if (i == 1) chk("lat1 cause", 32'(d1_cause), 1);
      if (d1_mem_rd) cnt_a++;
      if (d1_exc_busy) cnt_b++;
      if (d1_pc_wr) begin
        cnt_c++;
        if (at < 0) at = i;
      end
    end
    chk("lat1 mem_rd cycles", 32'(cnt_a), 1);
    chk("lat1 busy cycles", 32'(cnt_b), 2);
    chk("lat1 pc_wr cycles", 32'(cnt_c), 1);
    chk("lat1 pc_wr offset", 32'(at), 2);
    chk("lat1 pc_out", d1_pc_out, 32'h39);

    // Overflow held, Div0 pulses during READ.
    do_reset(1);
    @(negedge clk);
    exc_req = 3'b010; pc_in = 32'h0000_0200; mem_data = 32'h0000_0011;
    @(negedge clk);
    exc_req = 3'b110;
    @(negedge clk);
    exc_req = 3'b010;
    @(negedge clk);
    chk("b2b first pc_wr", 32'(pc_wr), 1);
    chk("b2b first cause", 32'(cause), 1);
    @(negedge clk);
    exc_req = 3'b000;
`ifdef EXC_PENDING_EN
    chk("b2b second cause", 32'(cause), 2);
    chk("b2b second addr", mem_addr, 255);
`else
    chk("b2b second cause", 32'(cause), 1);
    chk("b2b second addr", mem_addr, 254);
`endif
    chk("b2b second mem_rd", 32'(mem_rd), 1);
    chk("b2b second busy", 32'(exc_busy), 1);
    repeat (12) @(negedge clk);
    chk("b2b drained", 32'(exc_busy), 0);

    // Randomized run against the reference model.
    for (int c = 0; c <= 600; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("rnd mem_rd", 32'(mem_rd), 32'(age >= 1 && age <= ML));
        chk("rnd pc_wr", 32'(pc_wr), 32'(age == ML + 1));
        chk("rnd busy", 32'(exc_busy), 32'(age != 0));
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd pc_out", pc_out, m_pc);
        chk("rnd epc", epc, m_epc);
        chk("rnd cause", 32'(cause), 32'(m_cause));
      end
      reset    = (c == 0) || ($urandom_range(0, 59) == 0);
      exc_req  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      pc_in    = $urandom;
      mem_data = $urandom;
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised exception sequencer for the multicycle CPU, generalising the fixed three-way exception-vector select into a clocked unit. It priority-encodes NUM_EXC exception request lines, latches EPC and cause, and reads the handler byte from memory at VEC_BASE + cause. It then drives a one-cycle PC write with the zero-extended handler address. It sits between the datapath exception flags, the memory address mux and the PC register, and runs alongside the main control FSM.

## Interface
- NUM_EXC, 3, number of exception sources (2..8); index 0 = OPCODE, 1 = Overflow, 2 = Div0
- VEC_BASE, 253, byte address of vector slot for index 0; slot i at VEC_BASE + i
- MEM_LAT, 2, memory read latency in cycles (1..7)
- EPC_ADJ, 4, value subtracted from pc_in when latching EPC
- clk, input, 1, single clock, rising edge
- reset, input, 1, synchronous, active-high
- exc_req, input, NUM_EXC, exception request flags, level, sampled in IDLE
- pc_in, input, 32, current PC (already incremented)
- mem_data, input, 32, memory read data; handler address is bits [7:0]
- mem_addr, output, 32, vector slot address; valid while mem_rd high
- mem_rd, output, 1, memory read request
- pc_out, output, 32, {24'b0, handler byte}
- pc_wr, output, 1, one-cycle PC load strobe
- epc, output, 32, pc_in − EPC_ADJ captured at acceptance
- cause, output, clog2(NUM_EXC), index of the accepted exception
- exc_busy, output, 1, high in every state except IDLE; control FSM stalls on it

## Operation
- All outputs registered; reset value 0 for every output; state ← IDLE.
- Priority: highest set index wins (Div0 > Overflow > OPCODE).
- States: IDLE, READ, LOAD.
- IDLE, any exc_req bit set: epc ← pc_in − EPC_ADJ (mod 2^32), cause ← winning index, mem_addr ← VEC_BASE + cause, mem_rd ← 1, counter ← MEM_LAT−1, state → READ.
- READ: counter decrements each cycle. At counter = 0: handler ← mem_data[7:0], mem_rd ← 0, pc_out ← handler zero-extended, pc_wr ← 1, state → LOAD.
- LOAD: pc_wr ← 0, state → IDLE. epc and cause hold until the next acceptance.
- Requests seen in READ/LOAD: handled per Configuration.
- reset in any state: immediate return to IDLE, all outputs 0, pending cleared; reset wins over a simultaneous request.
- exc_req = 0 in IDLE: no state change, outputs hold.

## Timing
- Edge E0 accepts the request. mem_rd is high for MEM_LAT cycles after E0. pc_wr is high for exactly the one cycle after edge E0 + MEM_LAT.
- Request to pc_wr latency: MEM_LAT + 1 cycles. exc_busy is high for MEM_LAT + 1 cycles.
- mem_data is sampled on the last READ edge only.
- Back-to-back: the earliest next acceptance is on the edge that leaves LOAD.

## Configuration
- EXC_PENDING_EN defined: a NUM_EXC-bit sticky pending register ORs in exc_req every cycle outside IDLE. IDLE arbitrates on exc_req | pending, and the accepted bit is cleared. A request raised during READ is serviced right after LOAD with no loss.
- Undefined: requests outside IDLE are ignored; only live exc_req is seen in IDLE.

## Structure
- Package exc_pkg: state enum (IDLE, READ, LOAD), index constants EXC_OPCODE=0, EXC_OVF=1, EXC_DIV0=2, default VEC_BASE.
- Sub-module exc_prio_enc: combinational NUM_EXC-input highest-index priority encoder giving a valid flag and an index.

## Test plan
- reset held 3 cycles mid-READ, with exc_req=3'b111 → all outputs 0, state IDLE; no pc_wr after release until a new request.
- exc_req=3'b001, pc_in=0x40, mem_data[7:0]=0x80 → mem_addr=253, epc=0x3C, cause=0, pc_out=0x80, pc_wr at E0+3 (MEM_LAT=2).
- exc_req=3'b110 → cause=2, mem_addr=255; exc_req=3'b011 → cause=1, mem_addr=254.
- MEM_LAT=1 build, exc_req=3'b010 → mem_rd one cycle, pc_wr at E0+2, exc_busy 2 cycles.
- Overflow held while Div0 pulses during READ → with EXC_PENDING_EN, second sequence starts on the LOAD exit edge with cause=2. Without it, Div0 is dropped and Overflow is re-accepted.
- pc_in=0x2, EPC_ADJ=4 → epc=0xFFFFFFFE (wrap).
